// File: rtl/proximity_pkg.sv
// Shared types, default thresholds and helpers for the proximity guard.
package proximity_pkg;

    typedef enum logic [3:0] {
        MV_FWD   = 4'b0000,
        MV_FWD_L = 4'b0001,
        MV_FWD_R = 4'b0010,
        MV_REV   = 4'b0011,
        MV_CCW   = 4'b0100,
        MV_CW    = 4'b0101,
        MV_REV_L = 4'b0110,
        MV_REV_R = 4'b0111,
        MV_STOP  = 4'b1000
    } move_cmd_e;

    typedef enum logic [1:0] {
        ZONE_CLEAR   = 2'b00,
        ZONE_WARN    = 2'b01,
        ZONE_BLOCKED = 2'b10
    } zone_e;

    localparam int unsigned STOP_DIST_DEF      = 15;
    localparam int unsigned WARN_DIST_DEF      = 40;
    localparam int unsigned HYST_DEF           = 5;
    localparam int unsigned CONFIRM_N_DEF      = 3;
    localparam int unsigned STALE_CYCLES_DEF   = 5_000_000;
    localparam int unsigned REFRESH_CYCLES_DEF = 2_500_000;
    localparam logic [3:0]  WARN_SPEED_DEF     = 4'd2;

    function automatic logic is_forward(input logic [3:0] code);
        return (code == MV_FWD) || (code == MV_FWD_L) || (code == MV_FWD_R);
    endfunction

    // Leave-zone thresholds are base+hysteresis, clamped to the 8-bit range.
    function automatic logic [7:0] sat_thresh(input int unsigned base, input int unsigned add);
        logic [8:0] sum;
        sum = 9'(base) + 9'(add);
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/proximity_guard_if.sv
// Filtered move/speed command channel towards the UART motor transmitter.
interface proximity_guard_if;
    logic [3:0] cmd_out;
    logic [3:0] speed_out;
    logic       cmd_valid;
    logic       cmd_ready;

    modport master (output cmd_out, output speed_out, output cmd_valid, input cmd_ready);
    modport slave  (input cmd_out, input speed_out, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/proximity_zone_fsm.sv
// Range zone classifier: sample qualification, confirm run counter, stale timeout.
//   state        | meaning
//   ZONE_CLEAR   | nothing close, all moves pass
//   ZONE_WARN    | obstacle approaching
//   ZONE_BLOCKED | obstacle too close or sensor silent; forward moves vetoed
module proximity_zone_fsm
    import proximity_pkg::*;
#(
    parameter int unsigned STOP_DIST    = STOP_DIST_DEF,
    parameter int unsigned WARN_DIST    = WARN_DIST_DEF,
    parameter int unsigned HYST         = HYST_DEF,
    parameter int unsigned CONFIRM_N    = CONFIRM_N_DEF,
    parameter int unsigned STALE_CYCLES = STALE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dist_in,
    input  logic       dist_valid,
    output zone_e      zone,
    output logic       stale
);

    localparam int unsigned CW = $clog2(CONFIRM_N) + 1;
    localparam int unsigned TW = $clog2(STALE_CYCLES + 1);

    localparam logic [7:0]    STOP_T     = sat_thresh(STOP_DIST, 0);
    localparam logic [7:0]    WARN_T     = sat_thresh(WARN_DIST, 0);
    localparam logic [7:0]    LEAVE_WARN = sat_thresh(WARN_DIST, HYST);
    localparam logic [7:0]    LEAVE_BLK  = sat_thresh(STOP_DIST, HYST);
    localparam logic [CW-1:0] CONFIRM_TC = CW'(CONFIRM_N - 1);
    localparam logic [TW-1:0] STALE_TC   = TW'(STALE_CYCLES - 1);
    localparam logic [TW-1:0] STALE_MAX  = TW'(STALE_CYCLES);

    zone_e         zone_q, zone_d, relax_z;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] since_q, since_d;
    logic          stale_q, stale_d;
    logic          sample_ok, jump, qualify;

    always_ff @(posedge clk) begin
        if (rst) begin
            zone_q  <= ZONE_BLOCKED;
            cnt_q   <= '0;
            since_q <= '0;
            stale_q <= 1'b0;
        end else begin
            zone_q  <= zone_d;
            cnt_q   <= cnt_d;
            since_q <= since_d;
            stale_q <= stale_d;
        end
    end

    always_comb begin
        zone_d    = zone_q;
        cnt_d     = cnt_q;
        since_d   = since_q;
        stale_d   = stale_q;
        jump      = 1'b0;
        qualify   = 1'b0;
        relax_z   = ZONE_WARN;
        sample_ok = dist_valid && (dist_in != 8'd0);

        case (zone_q)
            ZONE_CLEAR: begin
                jump    = dist_in < STOP_T;
                qualify = dist_in < WARN_T;
                relax_z = ZONE_WARN;
            end
            ZONE_WARN: begin
                jump    = dist_in < STOP_T;
                qualify = dist_in >= LEAVE_WARN;
                relax_z = ZONE_CLEAR;
            end
            default: begin
                qualify = dist_in >= LEAVE_BLK;
                relax_z = ZONE_WARN;
            end
        endcase

        if (sample_ok) begin
            stale_d = 1'b0;
            since_d = '0;
            if (jump) begin
                zone_d = ZONE_BLOCKED;
                cnt_d  = '0;
            end else if (qualify) begin
                if (cnt_q == CONFIRM_TC) begin
                    zone_d = relax_z;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end else if (since_q != STALE_MAX) begin
            // Saturates at the terminal count so a silent sensor keeps stale asserted.
            since_d = since_q + TW'(1);
            if (since_q == STALE_TC) begin
                zone_d  = ZONE_BLOCKED;
                stale_d = 1'b1;
                cnt_d   = '0;
            end
        end
    end

    assign zone  = zone_q;
    assign stale = stale_q;

endmodule

// File: rtl/proximity_guard.sv
// Safety stage between command decoder and UART transmitter: vetoes forward moves when BLOCKED.
// Optional PROX_SLOWDOWN_EN caps speed in WARN and zeroes it for vetoed moves.
module proximity_guard
    import proximity_pkg::*;
#(
    parameter int unsigned STOP_DIST      = STOP_DIST_DEF,
    parameter int unsigned WARN_DIST      = WARN_DIST_DEF,
    parameter int unsigned HYST           = HYST_DEF,
    parameter int unsigned CONFIRM_N      = CONFIRM_N_DEF,
    parameter int unsigned STALE_CYCLES   = STALE_CYCLES_DEF,
`ifdef PROX_SLOWDOWN_EN
    parameter logic [3:0]  WARN_SPEED     = WARN_SPEED_DEF,
`endif
    parameter int unsigned REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        dist_in,
    input  logic              dist_valid,
    input  logic [3:0]        cmd_in,
    input  logic [3:0]        speed_in,
    proximity_guard_if.master tx,
    output logic [1:0]        zone,
    output logic              stale
);

    localparam int unsigned   RW           = $clog2(REFRESH_CYCLES + 1);
    localparam logic [RW-1:0] REFRESH_LOAD = RW'(REFRESH_CYCLES);

    zone_e         zone_w;
    logic          veto, launch;
    logic [3:0]    tgt_cmd, tgt_speed, last_cmd, last_speed;
    logic [RW-1:0] refresh_q;

    proximity_zone_fsm #(
        .STOP_DIST    (STOP_DIST),
        .WARN_DIST    (WARN_DIST),
        .HYST         (HYST),
        .CONFIRM_N    (CONFIRM_N),
        .STALE_CYCLES (STALE_CYCLES)
    ) u_zone (
        .clk        (clk),
        .rst        (rst),
        .dist_in    (dist_in),
        .dist_valid (dist_valid),
        .zone       (zone_w),
        .stale      (stale)
    );

    assign zone = zone_w;

    always_comb begin
        veto      = (zone_w == ZONE_BLOCKED) && is_forward(cmd_in);
        tgt_cmd   = (veto || (cmd_in > MV_STOP)) ? MV_STOP : cmd_in;
        tgt_speed = speed_in;
`ifdef PROX_SLOWDOWN_EN
        if ((zone_w == ZONE_WARN) && (speed_in > WARN_SPEED))
            tgt_speed = WARN_SPEED;
        if (veto)
            tgt_speed = 4'd0;
`endif
    end

    // Refresh timer idles at zero, so the first launch after reset is immediate.
    assign launch = !tx.cmd_valid &&
                    ((tgt_cmd != last_cmd) || (tgt_speed != last_speed) || (refresh_q == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            tx.cmd_out   <= MV_STOP;
            tx.speed_out <= 4'd0;
            tx.cmd_valid <= 1'b0;
            last_cmd     <= MV_STOP;
            last_speed   <= 4'd0;
            refresh_q    <= '0;
        end else begin
            if (refresh_q != '0)
                refresh_q <= refresh_q - RW'(1);
            if (tx.cmd_valid) begin
                if (tx.cmd_ready) begin
                    tx.cmd_valid <= 1'b0;
                    last_cmd     <= tx.cmd_out;
                    last_speed   <= tx.speed_out;
                    refresh_q    <= REFRESH_LOAD;
                end else if (veto && is_forward(tx.cmd_out)) begin
                    // A pending forward move must never reach the motors once blocked.
                    tx.cmd_out <= MV_STOP;
`ifdef PROX_SLOWDOWN_EN
                    tx.speed_out <= 4'd0;
`endif
                end
            end else if (launch) begin
                tx.cmd_out   <= tgt_cmd;
                tx.speed_out <= tgt_speed;
                tx.cmd_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_proximity_guard.sv
// Self-checking bench for proximity_guard: directed scenarios plus randomized lock-step model.
module tb_proximity_guard;

    localparam int STALE = 1000;
    localparam int REF   = 200;

    logic       clk;
    logic       rst;
    logic [7:0] dist_in;
    logic       dist_valid;
    logic [3:0] cmd_in;
    logic [3:0] speed_in;
    logic [1:0] zone;
    logic       stale;

    proximity_guard_if bus ();

    proximity_guard #(
        .STALE_CYCLES   (STALE),
        .REFRESH_CYCLES (REF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dist_in    (dist_in),
        .dist_valid (dist_valid),
        .cmd_in     (cmd_in),
        .speed_in   (speed_in),
        .tx         (bus),
        .zone       (zone),
        .stale      (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (zone: 0 clear, 1 warn, 2 blocked).
    int m_zone = 2, m_run = 0, m_since = 0, m_stale = 0;
    int m_cmd = 8, m_speed = 0, m_valid = 0, m_lcmd = 8, m_lspd = 0;
    int m_acc = 0, m_hav = 0;
    int n_edge = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        int z, run, since, st, c, s, v, lc, ls, acc, hav;
        int tc, ts, d;
        bit fwd, veto, good, expired;
        z = m_zone; run = m_run; since = m_since; st = m_stale;
        c = m_cmd; s = m_speed; v = m_valid; lc = m_lcmd; ls = m_lspd;
        acc = m_acc; hav = m_hav;
        d = int'(dist_in);
        if (rst) begin
            z = 2; run = 0; since = 0; st = 0;
            c = 8; s = 0; v = 0; lc = 8; ls = 0; hav = 0;
        end else begin
            fwd  = int'(cmd_in) <= 2;
            veto = (m_zone == 2) && fwd;
            tc   = (veto || int'(cmd_in) > 8) ? 8 : int'(cmd_in);
            ts   = int'(speed_in);
`ifdef PROX_SLOWDOWN_EN
            if (m_zone == 1 && ts > 2) ts = 2;
            if (veto) ts = 0;
`endif
            expired = !m_hav || ((n_edge + 1 - m_acc) > REF);
            if (m_valid != 0) begin
                if (bus.cmd_ready) begin
                    v = 0; lc = m_cmd; ls = m_speed; acc = n_edge + 1; hav = 1;
                end else if (veto && m_cmd <= 2) begin
                    c = 8;
`ifdef PROX_SLOWDOWN_EN
                    s = 0;
`endif
                end
            end else if (tc != m_lcmd || ts != m_lspd || expired) begin
                c = tc; s = ts; v = 1;
            end

            good = dist_valid && d != 0;
            if (good) begin
                st = 0; since = 0;
                if (m_zone != 2 && d < 15) begin
                    z = 2; run = 0;
                end else if ((m_zone == 0 && d < 40) || (m_zone == 1 && d >= 45) ||
                             (m_zone == 2 && d >= 20)) begin
                    run = m_run + 1;
                    if (run >= 3) begin
                        z = (m_zone == 1) ? 0 : 1;
                        run = 0;
                    end
                end else begin
                    run = 0;
                end
            end else if (m_since < STALE) begin
                since = m_since + 1;
                if (since == STALE) begin
                    z = 2; st = 1; run = 0;
                end
            end
        end
        @(posedge clk);
        n_edge++;
        m_zone = z; m_run = run; m_since = since; m_stale = st;
        m_cmd = c; m_speed = s; m_valid = v; m_lcmd = lc; m_lspd = ls;
        m_acc = acc; m_hav = hav;
        #1;
        check("zone", 32'(zone), 32'(m_zone));
        check("stale", 32'(stale), 32'(m_stale));
        check("cmd_valid", 32'(bus.cmd_valid), 32'(m_valid));
        if (m_valid != 0 || bus.cmd_valid) begin
            check("cmd_out", 32'(bus.cmd_out), 32'(m_cmd));
            check("speed_out", 32'(bus.speed_out), 32'(m_speed));
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic sample(input int d);
        dist_in = 8'(d);
        dist_valid = 1'b1;
        step();
        dist_valid = 1'b0;
        idle(3);
    endtask

    initial begin
        rst = 1'b1; dist_in = 8'd0; dist_valid = 1'b0;
        cmd_in = 4'd0; speed_in = 4'd5; bus.cmd_ready = 1'b1;
        idle(3);
        check("rst_zone", 32'(zone), 32'd2);
        check("rst_stale", 32'(stale), 32'd0);
        check("rst_cmd", 32'(bus.cmd_out), 32'd8);
        check("rst_speed", 32'(bus.speed_out), 32'd0);
        check("rst_valid", 32'(bus.cmd_valid), 32'd0);
        rst = 1'b0;
        step();
        check("first_launch_cmd", 32'(bus.cmd_out), 32'd8);

        // Leave BLOCKED, then relax to CLEAR.
        for (int i = 0; i < 3; i++) sample(50);
        check("t1_warn", 32'(zone), 32'd1);
        check("t1_cmd_fwd", 32'(bus.cmd_out), 32'd0);
        for (int i = 0; i < 3; i++) sample(50);
        check("t1_clear", 32'(zone), 32'd0);

        // Single close sample blocks immediately; launch of STOP follows.
        dist_in = 8'd10; dist_valid = 1'b1;
        step();
        check("t2_blocked", 32'(zone), 32'd2);
        dist_valid = 1'b0;
        step();
        check("t2_valid", 32'(bus.cmd_valid), 32'd1);
        check("t2_stop", 32'(bus.cmd_out), 32'd8);
        idle(2);

        // Non-forward moves pass while blocked.
        cmd_in = 4'd3; idle(3);
        check("t3_rev", 32'(bus.cmd_out), 32'd3);
        cmd_in = 4'd4; idle(3);
        check("t3_ccw", 32'(bus.cmd_out), 32'd4);

        // Hysteresis boundary: 19 breaks the run, 20 qualifies.
        sample(18); sample(21); sample(19); sample(20);
        check("t4_hold", 32'(zone), 32'd2);
        sample(20);
        check("t4_run2", 32'(zone), 32'd2);
        sample(20);
        sample(20);
        check("t4_warn", 32'(zone), 32'd1);

        // Pending forward overwritten by veto, then exactly one transfer.
        bus.cmd_ready = 1'b0; cmd_in = 4'd1; idle(2);
        check("t5_pend", 32'(bus.cmd_out), 32'd1);
        sample(10);
        check("t5_veto_cmd", 32'(bus.cmd_out), 32'd8);
        check("t5_veto_valid", 32'(bus.cmd_valid), 32'd1);
        bus.cmd_ready = 1'b1; step();
        check("t5_accept", 32'(bus.cmd_valid), 32'd0);
        idle(5);
        check("t5_single", 32'(bus.cmd_valid), 32'd0);
        idle(REF + 10);

        // Stale timeout from CLEAR.
        cmd_in = 4'd0;
        for (int i = 0; i < 6; i++) sample(50);
        check("t6_clear", 32'(zone), 32'd0);
        idle(STALE - 10);
        check("t6_not_yet", 32'(stale), 32'd0);
        idle(10);
        check("t6_stale", 32'(stale), 32'd1);
        check("t6_blocked", 32'(zone), 32'd2);
        sample(0);
        check("t6_no_echo", 32'(stale), 32'd1);
        sample(60);
        check("t6_recover", 32'(stale), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.cmd_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) cmd_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) speed_in = 4'($urandom_range(0, 15));
            dist_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0: dist_in = 8'd0;
                1: dist_in = 8'($urandom_range(8, 24));
                2: dist_in = 8'($urandom_range(35, 50));
                3: dist_in = 8'd255;
                default: dist_in = 8'($urandom_range(0, 255));
            endcase
            if (i == 1500) begin
                rst = 1'b1; idle(2); rst = 1'b0;
            end
            if (i == 2500) begin
                dist_valid = 1'b0; idle(STALE + 50);
            end
            step();
        end
        dist_valid = 1'b0;
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
